// File: rtl/instr_fetch_if.sv
// Fetch-to-decode handshake bundle.
// master: fetch stage drives the head entry; slave: decode drives ready.
interface instr_fetch_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;

  modport master (
    output out_valid,
    output out_instruction,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instruction,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the ROM address, buffers two
// fetched {pc, instr} entries for decode, sticky fault on bad fetch.
module instr_fetch #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [63:0]   imem_address,
  input  logic [31:0]   imem_instruction,
  instr_fetch_if.master dec,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_target,
  output logic          fetch_fault,
  output logic [63:0]   fault_pc,
  output logic [31:0]   retire_count
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        head_q, head_d;
  logic        fault_q, fault_d;
  logic [63:0] fpc_q, fpc_d;
  logic [31:0] ret_q, ret_d;
  logic [63:0] bpc_q  [DEPTH];
  logic [31:0] bins_q [DEPTH];

  logic        pop;
  logic        redir;
  logic        attempt;
  logic        legal;
  logic        push;
  logic        wr_idx;
  logic [64:0] end_addr;

  // 65-bit end address so a PC near 2^64 cannot wrap into range
  assign end_addr = {1'b0, pc_q} + 65'd3;
  assign legal    = (pc_q[1:0] == 2'b00) &&
                    (end_addr < 65'(MEM_SIZE));

  assign pop     = dec.out_valid & dec.out_ready;
  assign redir   = redirect_valid && (state_q != S_FAULT);
  assign attempt = (state_q != S_FAULT) && !redirect_valid &&
                   ((state_q != S_FULL) || pop);
  assign push    = attempt && legal;
  // When full this selects the slot being popped this cycle
  assign wr_idx  = head_q ^ cnt_q[0];

  assign imem_address        = pc_q;
  assign dec.out_valid       = (cnt_q != 2'd0);
  assign dec.out_instruction = dec.out_valid ? bins_q[head_q] : 32'h0;
  assign dec.out_pc          = dec.out_valid ? bpc_q[head_q] : 64'h0;
  assign fetch_fault         = fault_q;
  assign fault_pc            = fpc_q;
  assign retire_count        = ret_q;

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    ret_d   = ret_q;
    if (redir) begin
      cnt_d = 2'd0;
      pc_d  = redirect_target;
    end else begin
      if (pop) begin
        head_d = ~head_q;
        ret_d  = ret_q + 32'd1;
      end
      if (push) begin
        pc_d = pc_q + 64'd4;
      end
      if (attempt && !legal) begin
        fault_d = 1'b1;
        fpc_d   = pc_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    state_d = S_RUN;
    unique case (1'b1)
      fault_d:                         state_d = S_FAULT;
      (!fault_d && cnt_d == FULL_CNT): state_d = S_FULL;
      default:                         state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      head_q  <= 1'b0;
      fault_q <= 1'b0;
      fpc_q   <= 64'h0;
      ret_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
      ret_q   <= ret_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        bpc_q[i]  <= 64'h0;
        bins_q[i] <= 32'h0;
      end
    end else if (push) begin
      bpc_q[wr_idx]  <= pc_q;
      bins_q[wr_idx] <= imem_instruction;
    end
  end

endmodule
